// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_sequencer_pkg                                                |
// | Shared opcode, FunSel, RegSel, MuxSel, ALU and T-state constants     |
// | plus the packed control word driven onto the datapath.               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package control_sequencer_pkg;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3
  } tstate_t;

  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_ST  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_INC = 4'h4;
  localparam logic [3:0] OP_BRA = 4'h5;
  localparam logic [3:0] OP_BNE = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] FUN_DEC  = 2'b00;
  localparam logic [1:0] FUN_INC  = 2'b01;
  localparam logic [1:0] FUN_LOAD = 2'b10;
  localparam logic [1:0] FUN_CLR  = 2'b11;

  // Register enables are active-low: a 0 bit selects that register.
  localparam logic [3:0] RF_NONE  = 4'b1111;
  localparam logic [3:0] RF_ALL   = 4'b0000;
  localparam logic [2:0] ARF_NONE = 3'b111;
  localparam logic [2:0] ARF_PC   = 3'b011;
  localparam logic [2:0] ARF_AR   = 3'b101;
  localparam logic [2:0] ARF_ALL  = 3'b000;

  localparam logic [1:0] OUT_AR = 2'b00;
  localparam logic [1:0] OUT_SP = 2'b01;
  localparam logic [1:0] OUT_PC = 2'b10;

  localparam logic [1:0] MUX_ALU  = 2'b00;
  localparam logic [1:0] MUX_MEM  = 2'b01;
  localparam logic [1:0] MUX_IR   = 2'b10;
  localparam logic [1:0] MUX_ARFC = 2'b11;
  localparam logic       MUXC_AOUT = 1'b0;

  localparam logic [3:0] ALU_PASSA = 4'b0000;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;

  localparam int FLAG_Z = 3;

  typedef struct packed {
    logic [1:0] rf_out_a_sel;
    logic [1:0] rf_out_b_sel;
    logic [1:0] rf_fun_sel;
    logic [3:0] rf_reg_sel;
    logic [3:0] alu_fun_sel;
    logic [1:0] arf_out_c_sel;
    logic [1:0] arf_out_d_sel;
    logic [1:0] arf_fun_sel;
    logic [2:0] arf_reg_sel;
    logic       ir_lh;
    logic       ir_enable;
    logic [1:0] ir_fun_sel;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic       mux_c_sel;
  } ctrl_t;

  // Active-low RF enable for one register; RSEL 00 is R1 (MSB).
  function automatic logic [3:0] rf_select(input logic [1:0] rsel);
    return ~(4'b1000 >> rsel);
  endfunction

  // Direct-mode LD and ST need the extra memory cycle.
  function automatic logic needs_t3(input logic [3:0] opcode, input logic mode);
    return (opcode == OP_ST) || ((opcode == OP_LD) && !mode);
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_sequencer_if                                                 |
// | Bus between the sequencer (master) and the datapath (slave).         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface control_sequencer_if;
  logic [15:0] IROut;
  logic [3:0]  ALUOutFlag;
  logic [1:0]  RF_OutASel;
  logic [1:0]  RF_OutBSel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RegSel;
  logic [3:0]  ALU_FunSel;
  logic [1:0]  ARF_OutCSel;
  logic [1:0]  ARF_OutDSel;
  logic [1:0]  ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH;
  logic        IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR;
  logic        Mem_CS;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic        MuxCSel;
  logic [2:0]  SeqCnt;
  logic        Halted;

  modport master (
    input  IROut, ALUOutFlag,
    output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
           ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
           IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
           MuxASel, MuxBSel, MuxCSel, SeqCnt, Halted
  );

  modport slave (
    output IROut, ALUOutFlag,
    input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
           ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
           IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
           MuxASel, MuxBSel, MuxCSel, SeqCnt, Halted
  );
endinterface
`default_nettype wire

// File: rtl/control_sequencer_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_sequencer_decode                                             |
// | Combinational control word from T-state, IR, flags and reset.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module control_sequencer_decode
  import control_sequencer_pkg::*;
(
  input  logic        reset_n,
  input  tstate_t     seq_cnt,
  input  logic [15:0] ir,
  input  logic [3:0]  flags,
  output ctrl_t       ctrl
);

  logic [3:0] opcode;
  logic       mode;
  logic [1:0] rsel;
  logic [1:0] src2;
  logic       unused_ok;

  assign opcode    = ir[15:12];
  assign mode      = ir[11];
  assign rsel      = ir[9:8];
  assign src2      = ir[1:0];
  // The address byte reaches the datapath through the IR muxes, not here.
  assign unused_ok = ^{ir[10], ir[7:2], flags[2:0]};

  // Idle word first, then the reset clear or the per-state micro-operation.
  always_comb begin
    ctrl             = '0;
    ctrl.rf_reg_sel  = RF_NONE;
    ctrl.arf_reg_sel = ARF_NONE;
    ctrl.mem_cs      = 1'b1;
    if (!reset_n) begin
      ctrl.rf_fun_sel  = FUN_CLR;
      ctrl.rf_reg_sel  = RF_ALL;
      ctrl.arf_fun_sel = FUN_CLR;
      ctrl.arf_reg_sel = ARF_ALL;
      ctrl.ir_enable   = 1'b1;
      ctrl.ir_fun_sel  = FUN_CLR;
    end else begin
      case (seq_cnt)
        T0, T1: begin
          ctrl.arf_out_d_sel = OUT_PC;
          ctrl.mem_cs        = 1'b0;
          ctrl.ir_enable     = 1'b1;
          ctrl.ir_fun_sel    = FUN_LOAD;
          ctrl.ir_lh         = (seq_cnt == T1);
          ctrl.arf_fun_sel   = FUN_INC;
          ctrl.arf_reg_sel   = ARF_PC;
        end
        T2: begin
          case (opcode)
            OP_LD: begin
              if (mode) begin
                ctrl.mux_a_sel  = MUX_IR;
                ctrl.rf_fun_sel = FUN_LOAD;
                ctrl.rf_reg_sel = rf_select(rsel);
              end else begin
                ctrl.mux_b_sel   = MUX_IR;
                ctrl.arf_fun_sel = FUN_LOAD;
                ctrl.arf_reg_sel = ARF_AR;
              end
            end
            OP_ST: begin
              ctrl.mux_b_sel   = MUX_IR;
              ctrl.arf_fun_sel = FUN_LOAD;
              ctrl.arf_reg_sel = ARF_AR;
            end
            OP_ADD, OP_SUB: begin
              ctrl.rf_out_a_sel = rsel;
              ctrl.rf_out_b_sel = src2;
              ctrl.mux_c_sel    = MUXC_AOUT;
              ctrl.alu_fun_sel  = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
              ctrl.mux_a_sel    = MUX_ALU;
              ctrl.rf_fun_sel   = FUN_LOAD;
              ctrl.rf_reg_sel   = rf_select(rsel);
            end
            OP_INC: begin
              ctrl.rf_fun_sel = FUN_INC;
              ctrl.rf_reg_sel = rf_select(rsel);
            end
            OP_BRA: begin
              ctrl.mux_b_sel   = MUX_IR;
              ctrl.arf_fun_sel = FUN_LOAD;
              ctrl.arf_reg_sel = ARF_PC;
            end
            OP_BNE: begin
              if (!flags[FLAG_Z]) begin
                ctrl.mux_b_sel   = MUX_IR;
                ctrl.arf_fun_sel = FUN_LOAD;
                ctrl.arf_reg_sel = ARF_PC;
              end
            end
            default: ;
          endcase
        end
        T3: begin
          ctrl.arf_out_d_sel = OUT_AR;
          if (opcode == OP_LD) begin
            ctrl.mem_cs     = 1'b0;
            ctrl.mux_a_sel  = MUX_MEM;
            ctrl.rf_fun_sel = FUN_LOAD;
            ctrl.rf_reg_sel = rf_select(rsel);
          end else if (opcode == OP_ST) begin
            ctrl.rf_out_a_sel = rsel;
            ctrl.mux_c_sel    = MUXC_AOUT;
            ctrl.alu_fun_sel  = ALU_PASSA;
            ctrl.mem_cs       = 1'b0;
            ctrl.mem_wr       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_sequencer                                                    |
// | T-state counter and halt flag; control word comes from the decoder.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic                Clock,
  input  logic                Reset,
  control_sequencer_if.master bus
);

  tstate_t seq_cnt;
  tstate_t seq_next;
  logic    halted;
  logic    halted_next;
  ctrl_t   ctrl;

  control_sequencer_decode u_decode (
    .reset_n (Reset),
    .seq_cnt (seq_cnt),
    .ir      (bus.IROut),
    .flags   (bus.ALUOutFlag),
    .ctrl    (ctrl)
  );

  // Sequence counter and halt flag, cleared by the synchronous reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      seq_cnt <= T0;
      halted  <= 1'b0;
    end else begin
      seq_cnt <= seq_next;
      halted  <= halted_next;
    end
  end

  // Next T-state: fetch two bytes, execute, optionally one memory cycle; HLT parks in T2.
  always_comb begin
    seq_next    = T0;
    halted_next = halted;
    case (seq_cnt)
      T0: seq_next = T1;
      T1: seq_next = T2;
      T2: begin
        if (halted || (bus.IROut[15:12] == OP_HLT)) begin
          seq_next    = T2;
          halted_next = 1'b1;
        end else if (needs_t3(bus.IROut[15:12], bus.IROut[11])) begin
          seq_next = T3;
        end
      end
      default: seq_next = T0;
    endcase
  end

  assign bus.RF_OutASel  = ctrl.rf_out_a_sel;
  assign bus.RF_OutBSel  = ctrl.rf_out_b_sel;
  assign bus.RF_FunSel   = ctrl.rf_fun_sel;
  assign bus.RF_RegSel   = ctrl.rf_reg_sel;
  assign bus.ALU_FunSel  = ctrl.alu_fun_sel;
  assign bus.ARF_OutCSel = ctrl.arf_out_c_sel;
  assign bus.ARF_OutDSel = ctrl.arf_out_d_sel;
  assign bus.ARF_FunSel  = ctrl.arf_fun_sel;
  assign bus.ARF_RegSel  = ctrl.arf_reg_sel;
  assign bus.IR_LH       = ctrl.ir_lh;
  assign bus.IR_Enable   = ctrl.ir_enable;
  assign bus.IR_Funsel   = ctrl.ir_fun_sel;
  assign bus.Mem_WR      = ctrl.mem_wr;
  assign bus.Mem_CS      = ctrl.mem_cs;
  assign bus.MuxASel     = ctrl.mux_a_sel;
  assign bus.MuxBSel     = ctrl.mux_b_sel;
  assign bus.MuxCSel     = ctrl.mux_c_sel;
  assign bus.SeqCnt      = seq_cnt;
  assign bus.Halted      = halted;

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have ports: Clock  in  1  system clock, rising edge; Reset  in  1  synchronous, active-low.
REQ-002 SHALL have inputs: IROut  in  16  instruction register; ALUOutFlag  in  4  {Z,C,N,O}.
REQ-003 SHALL have outputs driving the datapath: RF_OutASel 2, RF_OutBSel 2, RF_FunSel 2, RF_RegSel 4, ALU_FunSel 4, ARF_OutCSel 2, ARF_OutDSel 2, ARF_FunSel 2, ARF_RegSel 3, IR_LH 1, IR_Enable 1, IR_Funsel 2, Mem_WR 1, Mem_CS 1, MuxASel 2, MuxBSel 2, MuxCSel 1.
REQ-004 SHALL have status outputs: SeqCnt  out  3  current T-state; Halted  out  1  HLT executed.

Function
REQ-005 SHALL decode IROut as [15:12] OPCODE, [11] MODE (1 immediate, 0 direct), [9:8] RSEL (00 R1 .. 11 R4), [7:0] ADDRESS; IROut[1:0] is the second source register SRC2.
REQ-006 SHALL use encodings: FunSel DEC 00, INC 01, LOAD 10, CLR 11; RegSel bits active-low, RF {R1,R2,R3,R4}, ARF {PC,AR,SP}; ARF Out*Sel AR 00, SP 01, PC 10; MuxA/MuxB 00 ALUOut, 01 MemoryOut, 10 IROut[7:0], 11 ARF_COut; MuxC 0 AOut; ALU PASSA 0000, ADD 0100, SUB 0110; Mem_CS active-low, Mem_WR 1 write.
REQ-007 SHALL drive idle outputs in any cycle not otherwise specified: all RegSel 1s, IR_Enable 0, Mem_CS 1, Mem_WR 0, all selects and FunSel 0.
REQ-008 SHALL run a 3-bit sequence counter: T0 -> T1 -> T2 -> (T3 when required) -> T0.
REQ-009 T0: Address=PC, Mem_CS 0, IR_Enable 1, IR_Funsel LOAD, IR_LH 0 (low byte), PC INC.
REQ-010 T1: same as T0 with IR_LH 1 (high byte).
REQ-011 LD (0x0), MODE 1: T2 loads R[RSEL] from IROut[7:0] via MuxA 10, then T0.
REQ-012 LD, MODE 0: T2 loads AR from ADDRESS via MuxB 10; T3 loads R[RSEL] from M[AR] via MuxA 01, Mem_CS 0, OutDSel AR.
REQ-013 ST (0x1): T2 loads AR from ADDRESS; T3 OutASel RSEL, ALU PASSA, Mem_CS 0, Mem_WR 1, OutDSel AR.
REQ-014 ADD (0x2) / SUB (0x3): T2 OutASel RSEL, OutBSel SRC2, MuxC 0, ALU ADD/SUB, MuxA 00, R[RSEL] LOAD; 8-bit wrap, flags owned by ALU.
REQ-015 INC (0x4): T2 R[RSEL] INC, 0xFF wraps to 0x00.
REQ-016 BRA (0x5): T2 PC LOAD from ADDRESS via MuxB 10.
REQ-017 BNE (0x6): T2 samples ALUOutFlag[3]; Z=0 -> PC LOAD ADDRESS; Z=1 -> idle cycle.
REQ-018 HLT (0xF): T2 sets Halted; counter holds T2 with idle outputs until Reset.
REQ-019 Undefined opcodes (0x7-0xE) SHALL execute as a one-cycle NOP in T2.

Reset
REQ-020 While Reset=0 at a rising edge: SeqCnt <= T0, Halted <= 0.
REQ-021 While Reset=0, outputs SHALL drive datapath clear: RF_FunSel CLR, RF_RegSel 0000, ARF_FunSel CLR, ARF_RegSel 000, IR_Enable 1, IR_Funsel CLR; all others idle.
REQ-022 Reset mid-instruction SHALL abort it; the first cycle after release is T0 fetch with PC=0.

Structure
REQ-023 A shared package SHALL hold opcode, FunSel, RegSel, MuxSel, ALU_FunSel and T-state constants.
REQ-024 Outputs SHALL be combinational from {SeqCnt, IROut, ALUOutFlag, Reset}; only SeqCnt and Halted are registered.
REQ-025 The bench SHALL instantiate control_sequencer with the existing ALUSystem in a wrapper; no other sub-module.

Verification
REQ-026 Reset low 2 cycles, release -> T0 with Address=0, all RF/ARF/IR registers read 0.
REQ-027 M[0]=0x2A, M[1]=0x08 (LD R1 #0x2A) -> R1=0x2A after T2, PC=2, SeqCnt returns to T0.
REQ-028 LD R1 #0x05; LD R2 #0x03; SUB R1,R2 -> R1=0x02, Z=0; SUB R1,R1 -> R1=0x00, Z=1.
REQ-029 ST R1 to 0x80, then LD R3 direct 0x80 -> M[0x80]=R3=R1, each executes in exactly 4 cycles.
REQ-030 BNE 0x10 with Z=0 -> PC=0x10; Z=1 -> PC=previous+2; HLT -> Halted=1, SeqCnt frozen at T2.
REQ-031 Reset asserted during T3 of ST -> no memory write, next cycle after release is T0.
